// File: rtl/demo_seq_pkg.sv
// Shared opcodes, FSM states and instruction field positions for the demo sequencer.
package demo_seq_pkg;

  localparam int unsigned InstrW = 16;

  localparam int unsigned OpMsb = 15;
  localparam int unsigned OpLsb = 12;
  localparam int unsigned RdMsb = 11;
  localparam int unsigned RdLsb = 8;
  localparam int unsigned RsMsb = 7;
  localparam int unsigned RsLsb = 4;
  localparam int unsigned RtMsb = 3;
  localparam int unsigned RtLsb = 0;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpAdd  = 4'h1;
  localparam logic [3:0] OpSub  = 4'h2;
  localparam logic [3:0] OpAnd  = 4'h3;
  localparam logic [3:0] OpOr   = 4'h4;
  localparam logic [3:0] OpXor  = 4'h5;
  localparam logic [3:0] OpAddi = 4'h6;
  localparam logic [3:0] OpMovi = 4'h7;
  localparam logic [3:0] OpMov  = 4'h8;
  localparam logic [3:0] OpJmp  = 4'h9;
  localparam logic [3:0] OpBz   = 4'hA;
  localparam logic [3:0] OpHalt = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StWrite,
    StHalt
  } state_e;

  // Collapses reserved codes (and branches when disabled) onto NOP.
  function automatic logic [3:0] decode_op(input logic [3:0] op, input logic branch_en);
    logic [3:0] res;
    res = op;
    case (op)
      OpJmp, OpBz:                res = branch_en ? op : OpNop;
      4'hB, 4'hC, 4'hD, 4'hE:     res = OpNop;
      default:                    res = op;
    endcase
    return res;
  endfunction

  function automatic logic op_writes(input logic [3:0] op);
    return (op >= OpAdd) && (op <= OpMov);
  endfunction

endpackage

// File: rtl/demo_program_rom.sv
// Synchronous-read program ROM; the registered output doubles as the instruction register.
module demo_program_rom
  import demo_seq_pkg::*;
#(
  parameter int unsigned PROG_DEPTH = 16,
  parameter int unsigned PC_W = 4,
  parameter bit USE_IMAGE = 1'b0,
  parameter logic [PROG_DEPTH*InstrW-1:0] PROG_IMAGE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [PC_W-1:0]   addr,
  output logic [InstrW-1:0] instr
);

  logic [InstrW-1:0] word;

  always_comb begin
    word = '0;
    if (USE_IMAGE) begin
      word = PROG_IMAGE[int'(addr)*InstrW +: InstrW];
    end else begin
      case (int'(addr))
        0:       word = 16'h7103;  // MOVI r1,3
        1:       word = 16'h7205;  // MOVI r2,5
        2:       word = 16'h1102;  // ADD  r1,r2
        3:       word = 16'h9002;  // JMP  2
        4:       word = 16'hF000;  // HALT
        default: word = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr <= '0;
    end else if (en) begin
      instr <= word;
    end
  end

endmodule

// File: rtl/demo_sequencer.sv
// Microcoded FETCH/EXEC/WRITE sequencer driving the demo datapath.
// Define DEMO_SEQ_BRANCH_EN to enable JMP/BZ; otherwise they decode as NOP and zero is ignored.
module demo_sequencer
  import demo_seq_pkg::*;
#(
  parameter int unsigned PROG_DEPTH = 16,
  parameter int unsigned PC_W = 4,
  parameter bit USE_IMAGE = 1'b0,
  parameter logic [PROG_DEPTH*InstrW-1:0] PROG_IMAGE = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            step,
  input  logic            zero,
  output logic [3:0]      ra_addr,
  output logic [3:0]      rb_addr,
  output logic [3:0]      wr_addr,
  output logic            reg_we,
  output logic [3:0]      alu_op,
  output logic            use_imm,
  output logic [15:0]     imm,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              zero_q, zero_d;
  logic              zero_s;
  logic [InstrW-1:0] ir;
  logic [3:0]        op, rd, rs, rt, dop;
  logic [7:0]        jmp_field;

`ifdef DEMO_SEQ_BRANCH_EN
  localparam logic BranchEn = 1'b1;
  assign zero_s = zero;
`else
  localparam logic BranchEn = 1'b0;
  logic unused_zero;
  assign unused_zero = zero;
  assign zero_s = 1'b0;
`endif

  demo_program_rom #(
    .PROG_DEPTH (PROG_DEPTH),
    .PC_W       (PC_W),
    .USE_IMAGE  (USE_IMAGE),
    .PROG_IMAGE (PROG_IMAGE)
  ) u_rom (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == StFetch),
    .addr  (pc_q),
    .instr (ir)
  );

  assign op        = ir[OpMsb:OpLsb];
  assign rd        = ir[RdMsb:RdLsb];
  assign rs        = ir[RsMsb:RsLsb];
  assign rt        = ir[RtMsb:RtLsb];
  assign dop       = decode_op(op, BranchEn);
  assign jmp_field = {rs, rt};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle:  if (run || step) state_d = StFetch;
      StFetch: state_d = StExec;
      StExec: begin
        zero_d  = zero_s;
        state_d = (dop == OpHalt) ? StHalt : StWrite;
      end
      StWrite: begin
        state_d = run ? StFetch : StIdle;
        if (dop == OpJmp || (dop == OpBz && zero_q)) begin
          pc_d = jmp_field[PC_W-1:0];
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Decoded fields are presented in EXEC and held through WRITE.
  always_comb begin
    ra_addr = '0;
    rb_addr = '0;
    wr_addr = '0;
    reg_we  = 1'b0;
    alu_op  = '0;
    use_imm = 1'b0;
    imm     = '0;
    if (state_q == StExec || state_q == StWrite) begin
      ra_addr = rd;
      rb_addr = (dop == OpMov) ? rs : rt;
      wr_addr = rd;
      alu_op  = dop;
      if (dop == OpAddi || dop == OpMovi) begin
        use_imm = 1'b1;
        imm     = {12'b0, rt};
      end
      reg_we = (state_q == StWrite) && op_writes(dop);
    end
  end

  assign pc     = pc_q;
  assign halted = (state_q == StHalt);

endmodule

// File: doc/demo_sequencer.md
# demo_sequencer

Microcoded control FSM that sequences the complete datapath for the board demo. Steps a fixed program held in a small synchronous ROM, driving register-file addresses, ALU opcode, immediate selection and write enable, so the 16-bit result bus shown on the four seven-segment digits evolves visibly. Sits between the board buttons and the datapath, and replaces hard-wired control in the demo top level.

## Interface
- PROG_DEPTH, 16: ROM words; power of two.
- PC_W, 4: program-counter width, equal to log2(PROG_DEPTH).
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; while high, instructions execute back to back.
- step  in  1  one-cycle pulse, already synchronised and debounced; executes exactly one instruction from IDLE.
- zero  in  1  datapath ALU zero flag, sampled during EXEC.
- ra_addr  out  4  register-file read port A address.
- rb_addr  out  4  register-file read port B address.
- wr_addr  out  4  register-file write address.
- reg_we  out  1  register-file write enable.
- alu_op  out  4  ALU operation code.
- use_imm  out  1  selects the immediate instead of port B.
- imm  out  16  zero-extended 4-bit immediate.
- pc  out  PC_W  current program counter.
- halted  out  1  high in HALT.

## Operation
- Instruction word, 16 bits: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt or imm4.
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 ADDI, 7 MOVI, 8 MOV, 9 JMP, A BZ, F HALT. Codes B–E decode as NOP.
- States: IDLE, FETCH, EXEC, WRITE, HALT.
- IDLE: moves to FETCH when run=1 or step=1. When both are high, the instruction still executes once.
- FETCH: presents pc to the ROM. The word is registered into the instruction register at the end of the cycle.
- EXEC drives these outputs:
  - ra_addr=rd, rb_addr=rt, alu_op=op.
  - For ADDI and MOVI: use_imm=1, imm = {12'b0, imm4}.
  - MOV passes rs through with alu_op=8.
  - zero is sampled on this cycle for BZ.
- WRITE:
  - For ALU ops and MOV/MOVI: reg_we=1 for exactly this cycle, wr_addr=rd. Address, op and immediate outputs hold their EXEC values.
  - For NOP, JMP and BZ: reg_we stays 0.
  - pc update: JMP loads pc ← {rs,rt}[PC_W-1:0]. BZ loads the same value when the sampled zero=1. Otherwise pc ← pc+1.
- After WRITE: if run=1, go to FETCH; otherwise go to IDLE.
- HALT opcode: goes from EXEC directly to HALT, and pc does not advance. HALT is exited only by reset.
- pc wraps from PROG_DEPTH-1 to 0 with no flag.
- Outside EXEC and WRITE: reg_we=0, use_imm=0, imm=0, alu_op=0.
- step pulses that arrive outside IDLE are ignored, not queued.

## Timing
- Reset values: state=IDLE, pc=0, instruction register=0 (NOP), all outputs 0, halted=0.
- Assertion of reset mid-instruction, including in WRITE, clears state asynchronously. No partial write may follow release.
- Latency: step accepted in IDLE (cycle 0) → FETCH on cycle 1, EXEC on cycle 2, reg_we high on cycle 3, IDLE on cycle 4.
- Continuous run: one instruction per 3 cycles (FETCH, EXEC, WRITE).
- ROM read latency is exactly 1 cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from run, step or zero to any output.

## Configuration
- DEMO_SEQ_BRANCH_EN defined: JMP and BZ behave as above.
- DEMO_SEQ_BRANCH_EN undefined: opcodes 9 and A decode as NOP, pc always increments or holds at HALT, and the zero input is unused.

## Structure
- Shared package demo_seq_pkg holds:
  - the opcode localparams;
  - the state enum;
  - the instruction field bit positions.
- Sub-module demo_program_rom: synchronous read, PROG_DEPTH×16, contents in a case statement.
- Default demo program, at pc 0–4: MOVI r1,3; MOVI r2,5; ADD r1,r2; JMP 2; HALT.
- A test-only override of the ROM contents is allowed from the bench.

## Test plan
- Reset with run=0 and one step pulse → FETCH, EXEC, then reg_we=1 on cycle 3 with wr_addr=1, use_imm=1, imm=0x0003, alu_op=7. Ends in IDLE with pc=1.
- run held high from reset over 9 cycles → three reg_we pulses spaced 3 cycles apart. pc sequence is 0, 1, 2, 3.
- With DEMO_SEQ_BRANCH_EN, run through JMP 2 → pc returns to 2. ADD r1,r2 is repeated every 6 cycles.
- Program with BZ 7 and zero=1 sampled in EXEC → pc=7. With zero=0 → pc increments.
- HALT at pc=4 → halted=1 and pc stays 4. Further step or run has no effect until reset.
- Reset asserted during WRITE → reg_we drops immediately, and pc=0 and state=IDLE after release. Also, a step pulse during EXEC is ignored.
